// File: rtl/motor_pkg.sv
// Shared motor-drive types and constants, used by the command ramp and the PWM stage.
package motor_pkg;

  localparam int unsigned DUTY_W = 16;
  localparam int unsigned CALC_W = DUTY_W + 1;
  localparam logic [DUTY_W-1:0] PERIOD_DEF = 16'd999;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    REVERSE,
    STOP
  } ramp_state_e;

  // Duty value meaning 100 % high for a given period (period+1), saturated to the duty width.
  function automatic logic [DUTY_W-1:0] full_scale(input logic [DUTY_W-1:0] per);
    logic [CALC_W-1:0] sum;
    sum = CALC_W'(per) + CALC_W'(1);
    return sum[DUTY_W] ? {DUTY_W{1'b1}} : sum[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/motor_cmd_ramp_if.sv
// Host command handshake into the motor command ramp.
interface motor_cmd_ramp_if;

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [motor_pkg::DUTY_W-1:0]  cmd_duty;
  logic [motor_pkg::DUTY_W-1:0]  cmd_period;
  logic                          cmd_dir;

  modport master (
    output cmd_valid,
    output cmd_duty,
    output cmd_period,
    output cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_duty,
    input  cmd_period,
    input  cmd_dir,
    output cmd_ready
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for the one cycle in DIV where the count is DIV-1.
module tick_prescaler #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
  end

  // tick is registered so that it is high exactly while cnt == LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= (DIV == 1);
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/motor_cmd_ramp.sv
// Slew-rate-limited duty/period/direction command stage feeding the PWM generator.
// Direction reversals always ramp duty to zero before dir flips.
module motor_cmd_ramp #(
  parameter int unsigned                   TICK_DIV   = 1000,
  parameter int unsigned                   STEP       = 16,
  parameter logic [motor_pkg::DUTY_W-1:0]  PERIOD_DEF = motor_pkg::PERIOD_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  motor_cmd_ramp_if.slave               cmd,
  input  logic                          estop,
  output logic [motor_pkg::DUTY_W-1:0]  period,
  output logic [motor_pkg::DUTY_W-1:0]  duty,
  output logic                          dir,
  output logic                          busy
);

  import motor_pkg::*;

  localparam logic [CALC_W-1:0] STEP_C = CALC_W'(STEP);

  ramp_state_e       state, state_nxt;
  logic [DUTY_W-1:0] target, target_nxt;
  logic [DUTY_W-1:0] duty_nxt, period_nxt;
  logic              dir_nxt;
  logic              pending_dir, pending_dir_nxt;
  logic              tick;
  logic              accept;

  logic [DUTY_W-1:0] fs;
  logic [DUTY_W-1:0] cmd_target;
  logic [DUTY_W-1:0] duty_clamp;
  logic [DUTY_W-1:0] goal;
  logic [DUTY_W-1:0] stepped;
  logic [CALC_W-1:0] duty_w, goal_w, diff;

  tick_prescaler #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign cmd.cmd_ready = !estop && (state != STOP);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // One rate-limited step toward goal; REVERSE always heads for zero.
  always_comb begin
    goal   = (state == REVERSE) ? '0 : target;
    duty_w = CALC_W'(duty);
    goal_w = CALC_W'(goal);
    diff   = '0;
    if (goal_w >= duty_w) begin
      diff    = goal_w - duty_w;
      stepped = (diff <= STEP_C) ? goal : DUTY_W'(duty_w + STEP_C);
    end else begin
      diff    = duty_w - goal_w;
      stepped = (diff <= STEP_C) ? goal : DUTY_W'(duty_w - STEP_C);
    end
  end

  // Command clamping against the new period's 100 % value.
  always_comb begin
    fs         = full_scale(cmd.cmd_period);
    cmd_target = (cmd.cmd_duty > fs) ? fs : cmd.cmd_duty;
    duty_clamp = (duty > fs) ? fs : duty;
  end

  always_comb begin
    state_nxt       = state;
    target_nxt      = target;
    duty_nxt        = duty;
    period_nxt      = period;
    dir_nxt         = dir;
    pending_dir_nxt = pending_dir;

    if (estop) begin
      duty_nxt   = '0;
      target_nxt = '0;
      state_nxt  = STOP;
    end else if (state == STOP) begin
      state_nxt = IDLE;
    end else if (accept) begin
      // Accept wins over a coincident tick: that tick produces no step.
      period_nxt = cmd.cmd_period;
      target_nxt = cmd_target;
      duty_nxt   = duty_clamp;
      if ((cmd.cmd_dir == dir) || (duty_clamp == '0)) begin
        dir_nxt   = cmd.cmd_dir;
        state_nxt = RAMP;
      end else begin
        pending_dir_nxt = cmd.cmd_dir;
        state_nxt       = REVERSE;
      end
    end else begin
      case (state)
        RAMP: begin
          if (duty == target) begin
            state_nxt = IDLE;
          end else if (tick) begin
            duty_nxt = stepped;
          end
        end
        REVERSE: begin
          if (duty == '0) begin
            dir_nxt   = pending_dir;
            state_nxt = RAMP;
          end else if (tick) begin
            duty_nxt = stepped;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      target      <= '0;
      pending_dir <= 1'b0;
      period      <= PERIOD_DEF;
      duty        <= '0;
      dir         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      target      <= target_nxt;
      pending_dir <= pending_dir_nxt;
      period      <= period_nxt;
      duty        <= duty_nxt;
      dir         <= dir_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Directed bench for motor_cmd_ramp with TICK_DIV=4, STEP=16.
module tb_motor_cmd_ramp;

  logic        clk;
  logic        rst_n;
  logic        estop;
  logic [15:0] period;
  logic [15:0] duty;
  logic        dir;
  logic        busy;

  int checks;
  int errors;
  int dir_viol;

  localparam logic [15:0] UP_SEQ   [7] = '{16'd16, 16'd32, 16'd48, 16'd64, 16'd80, 16'd96, 16'd100};
  localparam logic [15:0] DOWN_SEQ [7] = '{16'd84, 16'd68, 16'd52, 16'd36, 16'd20, 16'd4, 16'd0};
  localparam logic [15:0] REUP_SEQ [3] = '{16'd16, 16'd32, 16'd40};

  motor_cmd_ramp_if cmd_if ();

  motor_cmd_ramp #(
    .TICK_DIV   (4),
    .STEP       (16),
    .PERIOD_DEF (16'd999)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd    (cmd_if),
    .estop  (estop),
    .period (period),
    .duty   (duty),
    .dir    (dir),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] p, input logic dr);
    cmd_if.cmd_duty   = d;
    cmd_if.cmd_period = p;
    cmd_if.cmd_dir    = dr;
    cmd_if.cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b0;
  endtask

  // Wait for the next duty change and compare it; n = cycles waited.
  task automatic wait_duty(input string tag, input logic [15:0] exp, input int budget, output int n);
    logic [15:0] start;
    logic        ldir;
    start = duty;
    ldir  = dir;
    n     = 0;
    do begin
      @(negedge clk);
      n++;
      if (dir != ldir && duty != 16'd0) dir_viol++;
      ldir = dir;
    end while (duty == start && n < budget);
    chk(tag, duty, exp);
  endtask

  task automatic wait_until(input string tag, input logic [15:0] exp, input int budget);
    int n;
    n = 0;
    while (duty != exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, duty, exp);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    int n;
    int total;
    checks   = 0;
    errors   = 0;
    dir_viol = 0;
    rst_n    = 1'b0;
    estop    = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_duty   = '0;
    cmd_if.cmd_period = '0;
    cmd_if.cmd_dir    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_period", period, 999);
    chk("rst_duty", duty, 0);
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_if.cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp 0 -> 100 in direction 0
    send(16'd100, 16'd999, 1'b0);
    chk("acc_period", period, 999);
    chk("acc_busy", busy, 1);
    total = 0;
    for (int i = 0; i < 7; i++) begin
      wait_duty("ramp_up", UP_SEQ[i], 8, n);
      total += n;
    end
    chk("ramp_cycles_le28", (total <= 28), 1);
    chk("busy_hold", busy, 1);
    @(negedge clk);
    chk("busy_fall", busy, 0);

    // Reversal to duty 40, direction 1
    send(16'd40, 16'd999, 1'b1);
    chk("rev_dir_kept", dir, 0);
    for (int i = 0; i < 7; i++) wait_duty("rev_down", DOWN_SEQ[i], 8, n);
    chk("rev_dir_at_zero", dir, 0);
    @(negedge clk);
    chk("rev_dir_flip", dir, 1);
    for (int i = 0; i < 3; i++) wait_duty("rev_up", REUP_SEQ[i], 8, n);
    chk("dir_only_at_zero", dir_viol, 0);
    wait_idle("rev_idle", 4);

    // Target clamp to period+1, then clamp on period shrink
    send(16'd5000, 16'd999, 1'b1);
    wait_until("clamp_target", 16'd1000, 300);
    repeat (6) @(negedge clk);
    chk("no_overshoot", duty, 1000);
    chk("clamp_idle", busy, 0);
    send(16'd0, 16'd199, 1'b1);
    chk("shrink_duty", duty, 200);
    chk("shrink_period", period, 199);
    wait_duty("shrink_step", 16'd184, 8, n);
    wait_until("shrink_zero", 16'd0, 80);
    wait_idle("shrink_idle", 4);

    // estop mid-ramp at duty 64 with a command held
    send(16'd200, 16'd199, 1'b1);
    wait_duty("es_ramp", 16'd16, 8, n);
    wait_duty("es_ramp", 16'd32, 8, n);
    wait_duty("es_ramp", 16'd48, 8, n);
    wait_duty("es_ramp", 16'd64, 8, n);
    estop = 1'b1;
    cmd_if.cmd_duty   = 16'd300;
    cmd_if.cmd_period = 16'd500;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_valid  = 1'b1;
    @(negedge clk);
    chk("es_duty", duty, 0);
    chk("es_ready", cmd_if.cmd_ready, 0);
    chk("es_busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("es_period_hold", period, 199);
    chk("es_dir_hold", dir, 1);
    chk("es_duty_hold", duty, 0);
    estop = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    chk("es_rel_busy", busy, 0);
    chk("es_rel_duty", duty, 0);
    chk("es_rel_ready", cmd_if.cmd_ready, 1);
    chk("es_rel_period", period, 199);

    // Asynchronous reset in the middle of a reversal
    send(16'd200, 16'd999, 1'b1);
    wait_until("ar_up", 16'd200, 80);
    wait_idle("ar_idle", 4);
    send(16'd50, 16'd999, 1'b0);
    wait_until("ar_down", 16'd152, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_duty", duty, 0);
    chk("ar_period", period, 999);
    chk("ar_dir", dir, 0);
    chk("ar_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Command coincident with the 4th-cycle tick after reset release
    repeat (3) @(negedge clk);
    send(16'd100, 16'd999, 1'b0);
    chk("tk_no_step", duty, 0);
    chk("tk_busy", busy, 1);
    wait_duty("tk_step", 16'd16, 8, n);
    chk("tk_latency", n, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
